// File: rtl/dcache_pkg.sv
// Shared types and address-field constants for the direct-mapped L1 data cache.
package dcache_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned LINE_W   = 256;
  localparam int unsigned OFFSET_W = 5;
  localparam int unsigned WS_LSB   = 2;
  localparam int unsigned WS_W     = 3;
  localparam int unsigned IDX_LSB  = OFFSET_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MISS,
    S_WRITEBACK,
    S_ALLOCATE,
    S_REFILL_DONE
  } state_e;

endpackage

// File: rtl/dcache_if.sv
// CPU-side and memory-side bus of the data cache; signal suffixes are from the cache's view.
interface dcache_if;
  import dcache_pkg::*;

  logic                p1_req_i;
  logic                p1_write_i;
  logic [ADDR_W-1:0]   p1_addr_i;
  logic [WORD_W-1:0]   p1_data_i;
  logic [WORD_W-1:0]   p1_data_o;
  logic                p1_stall_o;
  logic                mem_enable_o;
  logic                mem_write_o;
  logic [ADDR_W-1:0]   mem_addr_o;
  logic [LINE_W-1:0]   mem_data_o;
  logic [LINE_W-1:0]   mem_data_i;
  logic                mem_ack_i;

  modport slave (
    input  p1_req_i, p1_write_i, p1_addr_i, p1_data_i, mem_data_i, mem_ack_i,
    output p1_data_o, p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  modport master (
    output p1_req_i, p1_write_i, p1_addr_i, p1_data_i, mem_data_i, mem_ack_i,
    input  p1_data_o, p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

endinterface

// File: rtl/dcache_sram.sv
// Tag/valid/dirty and line storage: asynchronous read, synchronous word or full-line write.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int unsigned LINES = 32,
  parameter int unsigned TAG_W = 22,
  parameter int unsigned IDX_W = $clog2(LINES)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic              valid_o,
  output logic              dirty_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [LINE_W-1:0] line_o,
  input  logic              word_we_i,
  input  logic [WS_W-1:0]   word_sel_i,
  input  logic [WORD_W-1:0] word_data_i,
  input  logic              line_we_i,
  input  logic [TAG_W-1:0]  line_tag_i,
  input  logic [LINE_W-1:0] line_data_i
);

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign line_o  = data_q[idx_i];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  // Tag and data arrays are deliberately left uncleared by reset.
  always_ff @(posedge clk_i) begin
    if (line_we_i) begin
      data_q[idx_i] <= line_data_i;
      tag_q[idx_i]  <= line_tag_i;
    end else if (word_we_i) begin
      data_q[idx_i][word_sel_i*WORD_W +: WORD_W] <= word_data_i;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate L1 D-cache controller: hit logic, miss FSM, bus muxing.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int unsigned LINES = 32,
  parameter int unsigned TAG_W = 22
) (
  input  logic      clk_i,
  input  logic      rst_i,
  dcache_if.slave   bus
);

  localparam int unsigned IDX_W = $clog2(LINES);

  state_e state_q, state_d;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  req_tag;
  logic [WS_W-1:0]   ws;
  logic              unused_addr_bits;
  logic              rd_valid, rd_dirty, hit;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_line;
  logic              word_we, line_we, stall;
  logic [WORD_W-1:0] rdata;

  assign idx              = bus.p1_addr_i[IDX_LSB +: IDX_W];
  assign req_tag          = bus.p1_addr_i[ADDR_W-1 -: TAG_W];
  assign ws               = bus.p1_addr_i[WS_LSB +: WS_W];
  assign unused_addr_bits = ^bus.p1_addr_i[1:0];
  assign hit              = rd_valid && (rd_tag == req_tag);

  dcache_sram #(.LINES(LINES), .TAG_W(TAG_W), .IDX_W(IDX_W)) u_sram (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .idx_i       (idx),
    .valid_o     (rd_valid),
    .dirty_o     (rd_dirty),
    .tag_o       (rd_tag),
    .line_o      (rd_line),
    .word_we_i   (word_we),
    .word_sel_i  (ws),
    .word_data_i (bus.p1_data_i),
    .line_we_i   (line_we),
    .line_tag_i  (req_tag),
    .line_data_i (bus.mem_data_i)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    stall            = 1'b0;
    rdata            = '0;
    word_we          = 1'b0;
    line_we          = 1'b0;
    bus.mem_enable_o = 1'b0;
    bus.mem_write_o  = 1'b0;
    bus.mem_addr_o   = '0;
    bus.mem_data_o   = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.p1_req_i) begin
          if (hit) begin
            if (bus.p1_write_i) word_we = 1'b1;
            else                rdata   = rd_line[ws*WORD_W +: WORD_W];
          end else begin
            stall   = 1'b1;
            state_d = S_MISS;
          end
        end
      end
      S_MISS: begin
        stall   = 1'b1;
        state_d = (rd_valid && rd_dirty) ? S_WRITEBACK : S_ALLOCATE;
      end
      S_WRITEBACK: begin
        stall            = 1'b1;
        bus.mem_enable_o = 1'b1;
        bus.mem_write_o  = 1'b1;
        bus.mem_addr_o   = {rd_tag, idx, {OFFSET_W{1'b0}}};
        bus.mem_data_o   = rd_line;
        if (bus.mem_ack_i) state_d = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        stall            = 1'b1;
        bus.mem_enable_o = 1'b1;
        bus.mem_addr_o   = {req_tag, idx, {OFFSET_W{1'b0}}};
        if (bus.mem_ack_i) begin
          line_we = 1'b1;
          state_d = S_REFILL_DONE;
        end
      end
      S_REFILL_DONE: begin
        stall   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A held request during reset must not see a stall or stale data.
  assign bus.p1_stall_o = rst_i & stall;
  assign bus.p1_data_o  = rst_i ? rdata : '0;

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: vector table plus reset and spurious-ack sequences.
module tb_dcache_controller;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dcache_if bus_if ();

  dcache_controller #(.LINES(32), .TAG_W(22)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus_if)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    int          exp_stalls;
    logic [31:0] exp_rdata;
    logic        exp_wb;
    logic [31:0] exp_wb_addr;
    int          wb_ws;
    logic [31:0] wb_word;
  } vec_t;

  int compared = 0;
  int mismatched = 0;

  int           ack_delay = 1;
  logic         spur = 1'b0;
  int           wb_count = 0;
  logic [31:0]  wb_addr;
  logic [255:0] wb_line;
  logic [255:0] mem [logic [31:0]];

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    logic [255:0] l;
    if (mem.exists(a)) return mem[a];
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = (a << 4) + k;
    return l;
  endfunction

  // Memory responder: acks in the delay-th cycle of each enabled transaction.
  initial begin : responder
    int cnt;
    cnt = 0;
    bus_if.mem_ack_i  = 1'b0;
    bus_if.mem_data_i = '0;
    forever begin
      @(negedge clk);
      bus_if.mem_ack_i = 1'b0;
      if (rst_n && bus_if.mem_enable_o) begin
        cnt++;
        if (cnt >= ack_delay) begin
          cnt = 0;
          bus_if.mem_ack_i = 1'b1;
          if (bus_if.mem_write_o) begin
            mem[bus_if.mem_addr_o] = bus_if.mem_data_o;
            wb_count++;
            wb_addr = bus_if.mem_addr_o;
            wb_line = bus_if.mem_data_o;
          end else begin
            bus_if.mem_data_i = mem_line(bus_if.mem_addr_o);
          end
        end
      end else begin
        cnt = 0;
        if (spur) bus_if.mem_ack_i = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    chk({name, " mem_enable"}, {31'd0, bus_if.mem_enable_o}, 32'd0);
    chk({name, " mem_write"},  {31'd0, bus_if.mem_write_o},  32'd0);
    chk({name, " mem_addr"},   bus_if.mem_addr_o,            32'd0);
    chk({name, " mem_data"},   {31'd0, |bus_if.mem_data_o},  32'd0);
    chk({name, " stall"},      {31'd0, bus_if.p1_stall_o},   32'd0);
    chk({name, " p1_data"},    bus_if.p1_data_o,             32'd0);
  endtask

  // Entered at posedge+1; returns at posedge+1 after the completing edge.
  task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output int stalls, output logic [31:0] rdata);
    bus_if.p1_req_i   = 1'b1;
    bus_if.p1_write_i = wr;
    bus_if.p1_addr_i  = a;
    bus_if.p1_data_i  = d;
    stalls = 0;
    #3;
    while (bus_if.p1_stall_o && stalls < 100) begin
      stalls++;
      @(posedge clk);
      #4;
    end
    if (stalls >= 100) begin
      mismatched++;
      compared++;
      $display("FAIL access_timeout: addr %h still stalled after %0d cycles, expected release", a, stalls);
    end
    rdata = bus_if.p1_data_o;
    @(posedge clk);
    #1;
    bus_if.p1_req_i = 1'b0;
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int          stalls;
    int          wb_before;
    logic [31:0] rd;
    ack_delay = v.delay;
    wb_before = wb_count;
    access(v.wr, v.addr, v.wdata, stalls, rd);
    chk({name, " stalls"}, stalls, v.exp_stalls);
    chk({name, " p1_data"}, rd, v.exp_rdata);
    chk({name, " wb_count"}, wb_count - wb_before, v.exp_wb ? 32'd1 : 32'd0);
    if (v.exp_wb) begin
      chk({name, " wb_addr"}, wb_addr, v.exp_wb_addr);
      chk({name, " wb_word"}, wb_line[v.wb_ws*32 +: 32], v.wb_word);
    end
  endtask

  vec_t vecs [12];

  initial begin : main
    int waited;
    vec_t v;

    vecs[0]  = '{1'b0, 32'h0000_0100, 32'h0,         3, 6, 32'h0000_1000, 1'b0, 32'h0,         0, 32'h0};
    vecs[1]  = '{1'b1, 32'h0000_0104, 32'hDEADBEEF,  3, 0, 32'h0,         1'b0, 32'h0,         0, 32'h0};
    vecs[2]  = '{1'b0, 32'h0000_0104, 32'h0,         3, 0, 32'hDEADBEEF,  1'b0, 32'h0,         0, 32'h0};
    vecs[3]  = '{1'b0, 32'h0000_0100, 32'h0,         3, 0, 32'h0000_1000, 1'b0, 32'h0,         0, 32'h0};
    vecs[4]  = '{1'b0, 32'h0000_0500, 32'h0,         2, 7, 32'h0000_5000, 1'b1, 32'h0000_0100, 1, 32'hDEADBEEF};
    vecs[5]  = '{1'b0, 32'h0000_0104, 32'h0,         1, 4, 32'hDEADBEEF,  1'b0, 32'h0,         0, 32'h0};
    vecs[6]  = '{1'b1, 32'h0000_2008, 32'h12345678,  1, 4, 32'h0,         1'b0, 32'h0,         0, 32'h0};
    vecs[7]  = '{1'b0, 32'h0000_2008, 32'h0,         1, 0, 32'h12345678,  1'b0, 32'h0,         0, 32'h0};
    vecs[8]  = '{1'b0, 32'h0000_2000, 32'h0,         1, 0, 32'h0002_0000, 1'b0, 32'h0,         0, 32'h0};
    vecs[9]  = '{1'b0, 32'h0000_201C, 32'h0,         1, 0, 32'h0002_0007, 1'b0, 32'h0,         0, 32'h0};
    vecs[10] = '{1'b0, 32'h0000_3000, 32'h0,         1, 5, 32'h0003_0000, 1'b1, 32'h0000_2000, 2, 32'h12345678};
    vecs[11] = '{1'b0, 32'h0000_2004, 32'h0,         1, 4, 32'h0002_0001, 1'b0, 32'h0,         0, 32'h0};

    rst_n = 1'b0;
    bus_if.p1_req_i   = 1'b0;
    bus_if.p1_write_i = 1'b0;
    bus_if.p1_addr_i  = '0;
    bus_if.p1_data_i  = '0;
    repeat (2) @(posedge clk);
    #4;
    check_idle_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Spurious ack while idle must leave state and outputs untouched.
    spur = 1'b1;
    #5;
    check_idle_outputs("spur_during");
    #1;
    spur = 1'b0;
    @(posedge clk);
    #4;
    check_idle_outputs("spur_after");
    @(posedge clk);
    #1;
    v = '{1'b0, 32'h0000_2004, 32'h0, 1, 0, 32'h0002_0001, 1'b0, 32'h0, 0, 32'h0};
    run_vec("spur_hit", v);
    v = '{1'b1, 32'h0000_2010, 32'hCAFEF00D, 1, 0, 32'h0, 1'b0, 32'h0, 0, 32'h0};
    run_vec("dirty_write", v);

    // Reset asserted mid-ALLOCATE with the request still held.
    ack_delay = 20;
    bus_if.p1_req_i   = 1'b1;
    bus_if.p1_write_i = 1'b0;
    bus_if.p1_addr_i  = 32'h0000_0040;
    waited = 0;
    #3;
    while (!(bus_if.mem_enable_o && !bus_if.mem_write_o) && waited < 10) begin
      waited++;
      @(posedge clk);
      #4;
    end
    chk("reach_allocate", {31'd0, bus_if.mem_enable_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("reset_mid_alloc");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus_if.p1_req_i = 1'b0;

    v = '{1'b0, 32'h0000_0040, 32'h0, 1, 4, 32'h0000_0400, 1'b0, 32'h0, 0, 32'h0};
    run_vec("post_reset_miss", v);
    // Dirty store to 0x2010 was lost; refetch returns the earlier written-back line.
    v = '{1'b0, 32'h0000_2010, 32'h0, 1, 4, 32'h0002_0004, 1'b0, 32'h0, 0, 32'h0};
    run_vec("dirty_lost", v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
